// File: rtl/ysyx_23060025_icache_if.sv
// IFU fetch handshake plus AXI4 read-address/read-data channels of the instruction cache.
// slave: the cache's view. master: the IFU/memory side that issues fetches and returns beats.
interface ysyx_23060025_icache_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_psel;
  logic [ADDR_WIDTH-1:0] in_paddr;
  logic                  in_pready;
  logic [DATA_WIDTH-1:0] in_prdata;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic                  rlast;

  modport slave (
    input  in_psel, in_paddr, arready, rdata, rresp, rvalid, rlast,
    output in_pready, in_prdata, araddr, arvalid, arlen, arsize, arburst, rready
  );

  modport master (
    output in_psel, in_paddr, arready, rdata, rresp, rvalid, rlast,
    input  in_pready, in_prdata, araddr, arvalid, arlen, arsize, arburst, rready
  );
endinterface

// File: rtl/ysyx_23060025_icache.sv
// Direct-mapped read-only instruction cache between the IFU and an AXI4 read port.
// Misses refill a whole line with one INCR burst; fencei_i invalidates every line.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module ysyx_23060025_icache #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned OFFSET_WIDTH = 4,
  parameter int unsigned INDEX_WIDTH  = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  ysyx_23060025_icache_if.slave        bus,
  input  logic                         fencei_i,
  output logic [31:0]                  perf_hit_cnt,
  output logic [31:0]                  perf_miss_cnt
);
  localparam int unsigned TagWidth = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int unsigned WordBits = OFFSET_WIDTH - 2;
  localparam int unsigned Words    = 2 ** WordBits;
  localparam int unsigned Lines    = 2 ** INDEX_WIDTH;

  typedef enum logic [2:0] {StIdle, StLookup, StAr, StR, StResp} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:2]   req_addr_q;
  logic [Lines-1:0]        valid_q;
  logic [TagWidth-1:0]     tag_q  [Lines];
  logic [DATA_WIDTH-1:0]   data_q [Lines][Words];
  logic [WordBits-1:0]     beat_q;
  logic                    err_q;
  logic                    fence_pend_q;
  logic [DATA_WIDTH-1:0]   resp_word_q;

  logic [INDEX_WIDTH-1:0]  idx;
  logic [TagWidth-1:0]     tag;
  logic [WordBits-1:0]     word;
  logic                    hit, r_beat, r_last, accept, inval;
  logic                    unused_paddr;

  assign unused_paddr = ^bus.in_paddr[1:0];

  assign idx    = req_addr_q[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
  assign tag    = req_addr_q[ADDR_WIDTH-1:OFFSET_WIDTH+INDEX_WIDTH];
  assign word   = req_addr_q[OFFSET_WIDTH-1:2];
  assign hit    = valid_q[idx] && (tag_q[idx] == tag);
  assign r_beat = (state_q == StR) && bus.rvalid;
  assign r_last = r_beat && bus.rlast;
  // A pending fence takes the first idle cycle; a waiting request is accepted on the next one.
  assign inval  = (state_q == StIdle) && (fencei_i || fence_pend_q);
  assign accept = (state_q == StIdle) && bus.in_psel && !fence_pend_q;

  assign bus.arlen   = 8'(Words - 1);
  assign bus.arsize  = 3'b010;
  assign bus.arburst = 2'b01;

  // Next-state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    bus.in_pready = 1'b0;
    bus.in_prdata = '0;
    bus.arvalid   = 1'b0;
    bus.araddr    = '0;
    bus.rready    = 1'b0;
    case (state_q)
      StIdle: if (accept) state_d = StLookup;
      StLookup: begin
        if (hit) begin
          bus.in_pready = 1'b1;
          bus.in_prdata = data_q[idx][word];
          state_d       = StIdle;
        end else begin
          state_d = StAr;
        end
      end
      StAr: begin
        bus.arvalid = 1'b1;
        bus.araddr  = {req_addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
        if (bus.arready) state_d = StR;
      end
      StR: begin
        bus.rready = 1'b1;
        if (bus.rvalid && bus.rlast) state_d = StResp;
      end
      StResp: begin
        bus.in_pready = 1'b1;
        bus.in_prdata = resp_word_q;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state: FSM, request latch, valid bits, burst bookkeeping, fence tracking.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      req_addr_q   <= '0;
      valid_q      <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      fence_pend_q <= 1'b0;
      resp_word_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) req_addr_q <= bus.in_paddr[ADDR_WIDTH-1:2];
      if (inval) begin
        valid_q <= '0;
      end else if (r_last) begin
        // A line with any error beat is returned once but never kept.
        valid_q[idx] <= !(err_q || (bus.rresp != 2'b00));
      end
      if (inval) begin
        fence_pend_q <= 1'b0;
      end else if (fencei_i) begin
        fence_pend_q <= 1'b1;
      end
      if (state_q == StAr) begin
        beat_q <= '0;
        err_q  <= 1'b0;
      end else if (r_beat) begin
        beat_q <= beat_q + 1'b1;
        err_q  <= err_q | (bus.rresp != 2'b00);
        if (beat_q == word) resp_word_q <= bus.rdata;
      end
    end
  end

  // Line storage; contents only matter once the valid bit is set, so no reset.
  always_ff @(posedge clock) begin
    if (r_beat) data_q[idx][beat_q] <= bus.rdata;
    if (r_last) tag_q[idx] <= tag;
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Count every lookup outcome.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == StLookup) begin
      if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`else
  assign perf_hit_cnt  = '0;
  assign perf_miss_cnt = '0;
`endif
endmodule

// File: tb/tb_ysyx_23060025_icache.sv
// Randomized bench for ysyx_23060025_icache: a line-residency model plus a behavioural
// memory that answers the AXI burst with random stalls, error beats and fence pulses.
module tb_ysyx_23060025_icache;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fencei_i = 1'b0;
  logic [31:0] perf_hit_cnt, perf_miss_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned exp_hits = 0;
  int unsigned exp_misses = 0;
  logic [31:0] resident [int];  // index -> resident line base address
  bit          fence_pend = 1'b0;
  bit          tail = 1'b0;     // DUT still finishing the previous response

  ysyx_23060025_icache_if bus ();

  ysyx_23060025_icache dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .fencei_i     (fencei_i),
    .perf_hit_cnt (perf_hit_cnt),
    .perf_miss_cnt(perf_miss_cnt)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h3000000) return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic check_counters();
`ifdef ICACHE_PERF_CNT_EN
    check_val("perf_hit_cnt", perf_hit_cnt, exp_hits);
    check_val("perf_miss_cnt", perf_miss_cnt, exp_misses);
`else
    check_val("perf_hit_cnt", perf_hit_cnt, 32'd0);
    check_val("perf_miss_cnt", perf_miss_cnt, 32'd0);
`endif
  endtask

  // One fetch; err_beat<0 means clean burst, fence_cyc 0 = with the request, >=3 = mid-flight.
  task automatic do_fetch(input logic [31:0] addr, input int gap, input int err_beat,
                          input int fence_cyc);
    logic [31:0] line;
    logic [31:0] got_data;
    int          idx;
    int          cyc, ar_cnt, beat, lat, exp_lat;
    bit          exp_hit, done, fence_late, ar_checked, last_seen;
    bit          p_arv, p_arr, p_rrdy, p_rv, p_rl;
    line = {addr[31:4], 4'h0};
    idx = int'(addr[7:4]);
    got_data = '0;
    cyc = 0; ar_cnt = 0; beat = 0; lat = 0;
    done = 0; fence_late = 0; ar_checked = 0; last_seen = 0;
    p_arv = 0; p_arr = 0; p_rrdy = 0; p_rv = 0; p_rl = 0;
    repeat (gap) @(negedge clock);
    exp_lat = (gap == 0 && tail) ? 2 : 1;
    if (fence_pend || fence_cyc == 0) begin
      resident.delete();
      fence_pend = 0;
    end
    exp_hit = resident.exists(idx) && (resident[idx] == line);
    if (exp_hit) exp_hits++;
    else exp_misses++;
    bus.in_psel = 1'b1;
    bus.in_paddr = addr;
    fencei_i = (fence_cyc == 0);
    while (!done) begin
      @(negedge clock);
      cyc++;
      fencei_i = 1'b0;
      if (p_arv && p_arr) ar_cnt++;
      if (p_rrdy && p_rv) begin
        beat++;
        if (p_rl) begin
          last_seen = 1;
          check_val("pready_after_rlast", {31'd0, bus.in_pready}, 32'd1);
        end
      end
      if (bus.in_pready) begin
        done = 1;
        lat = cyc;
        got_data = bus.in_prdata;
      end else if (cyc > 200) begin
        check_val("fetch_timeout", 32'(cyc), 32'd200);
        done = 1;
      end else begin
        if (bus.arvalid && !ar_checked) begin
          ar_checked = 1;
          check_val("araddr", bus.araddr, line);
          check_val("arlen", {24'd0, bus.arlen}, 32'd3);
          check_val("arsize_burst", {27'd0, bus.arsize, bus.arburst}, {27'd0, 3'b010, 2'b01});
        end
        bus.arready = bus.arvalid && ($urandom_range(0, 1) == 1);
        if (bus.rready && beat < 4) begin
          bus.rvalid = ($urandom_range(0, 2) != 0);
          bus.rdata  = mem_word(line + 32'(4 * beat));
          bus.rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
          bus.rlast  = (beat == 3);
        end else begin
          bus.rvalid = 1'b0;
          bus.rlast  = 1'b0;
          bus.rdata  = $urandom;
          bus.rresp  = 2'b00;
        end
        if (fence_cyc >= 3 && cyc == fence_cyc) begin
          fencei_i = 1'b1;
          fence_late = 1;
        end
        p_arv = bus.arvalid; p_arr = bus.arready; p_rrdy = bus.rready;
        p_rv = bus.rvalid; p_rl = bus.rlast;
      end
    end
    bus.in_psel = 1'b0;
    bus.arready = 1'b0;
    bus.rvalid = 1'b0;
    bus.rlast = 1'b0;
    fencei_i = 1'b0;
    check_val($sformatf("miss@%08h", addr), {31'd0, ar_cnt != 0}, {31'd0, !exp_hit});
    check_val($sformatf("prdata@%08h", addr), got_data, mem_word(addr));
    if (exp_hit) begin
      check_val("hit_latency", 32'(lat), 32'(exp_lat));
    end else begin
      check_val("ar_count", 32'(ar_cnt), 32'd1);
      check_val("rlast_seen", {31'd0, last_seen}, 32'd1);
      if (err_beat >= 0 && err_beat < 4) resident.delete(idx);
      else resident[idx] = line;
    end
    if (fence_late) fence_pend = 1;
    tail = 1;
  endtask

  task automatic reset_model();
    resident.delete();
    fence_pend = 0;
    tail = 0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  initial begin
    int k;
    bit seen_r;
    logic [31:0] a;
    int r, fc, eb;
    bus.in_psel = 0; bus.in_paddr = '0; bus.arready = 0; bus.rdata = '0;
    bus.rresp = '0; bus.rvalid = 0; bus.rlast = 0;
    #3;
    check_val("rst_pready", {31'd0, bus.in_pready}, 32'd0);
    check_val("rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
    check_val("rst_rready", {31'd0, bus.rready}, 32'd0);
    check_val("rst_prdata", bus.in_prdata, 32'd0);
    check_val("rst_araddr", bus.araddr, 32'd0);
    check_counters();
    @(negedge clock);
    reset = 1'b1;
    reset_model();

    // Directed scenarios.
    do_fetch(32'h3000_0000, 1, -1, -1);  // cold miss, word 0x11
    do_fetch(32'h3000_000C, 0, -1, -1);  // hit, 0x44
    do_fetch(32'h3000_0100, 1, -1, -1);  // same index, new tag
    do_fetch(32'h3000_0000, 1, -1, -1);  // evicted -> miss
    do_fetch(32'h3000_0010, 1, -1, 5);   // fence during refill
    do_fetch(32'h3000_0010, 0, -1, -1);  // fenced -> miss
    do_fetch(32'h3000_0014, 1, -1, -1);  // now resident
    do_fetch(32'h3000_0020, 1, 1, -1);   // error beat
    do_fetch(32'h3000_0024, 1, -1, -1);  // not validated -> miss
    do_fetch(32'h3000_0000, 2, -1, 0);   // fence with request

    // Reset asserted in the middle of a refill.
    @(negedge clock);
    bus.in_psel = 1'b1;
    bus.in_paddr = 32'h3000_0040;
    bus.arready = 1'b1;
    k = 0;
    while (!bus.rready && k < 50) begin
      @(negedge clock);
      k++;
    end
    seen_r = bus.rready;
    check_val("reached_r", {31'd0, seen_r}, 32'd1);
    bus.arready = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF; bus.rresp = 2'b00; bus.rlast = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_val("midrst_arvalid", {31'd0, bus.arvalid}, 32'd0);
    check_val("midrst_rready", {31'd0, bus.rready}, 32'd0);
    check_val("midrst_pready", {31'd0, bus.in_pready}, 32'd0);
    bus.in_psel = 1'b0;
    bus.rvalid = 1'b0;
    reset_model();
    check_counters();
    @(negedge clock);
    reset = 1'b1;

    // Three hits and two misses after reset; earlier lines must miss.
    do_fetch(32'h3000_0000, 1, -1, -1);
    do_fetch(32'h3000_0004, 1, -1, -1);
    do_fetch(32'h3000_0008, 0, -1, -1);
    do_fetch(32'h3000_0010, 1, -1, -1);
    do_fetch(32'h3000_0014, 2, -1, -1);
    check_counters();

    // Random traffic over 4 tags x 4 indices to mix hits, evictions, errors and fences.
    for (int i = 0; i < 150; i++) begin
      a = 32'h3000_0000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
          | (32'($urandom_range(0, 3)) << 2);
      eb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      r = int'($urandom_range(0, 11));
      fc = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(3, 8)) : -1;
      do_fetch(a, int'($urandom_range(0, 2)), eb, fc);
    end
    @(negedge clock);
    check_counters();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
